// File: rtl/dmi_sba_preloader_pkg.sv
// Shared DMI register map, command words and FSM encodings for the DMI/SBA boot preloader.
package dmi_sba_preloader_pkg;

  localparam logic [6:0] DMI_DATA0     = 7'h04;
  localparam logic [6:0] DMI_DMCONTROL = 7'h10;
  localparam logic [6:0] DMI_DMSTATUS  = 7'h11;
  localparam logic [6:0] DMI_COMMAND   = 7'h17;
  localparam logic [6:0] DMI_SBCS      = 7'h38;
  localparam logic [6:0] DMI_SBADDR0   = 7'h39;
  localparam logic [6:0] DMI_SBDATA0   = 7'h3C;

  typedef enum logic [1:0] {
    DMI_NOP   = 2'd0,
    DMI_READ  = 2'd1,
    DMI_WRITE = 2'd2
  } dmi_op_e;

  typedef logic [4:0] state_e;
  localparam state_e S_IDLE  = 5'd0;
  localparam state_e S_ACT   = 5'd1;
  localparam state_e S_SBCFG = 5'd2;
  localparam state_e S_HDR   = 5'd3;
  localparam state_e S_ADDR  = 5'd4;
  localparam state_e S_DATA  = 5'd5;
  localparam state_e S_POLL  = 5'd6;
  localparam state_e S_SBOFF = 5'd7;
  localparam state_e S_PC    = 5'd8;
  localparam state_e S_HALT  = 5'd9;
  localparam state_e S_WHALT = 5'd10;
  localparam state_e S_CLR   = 5'd11;
  localparam state_e S_CMD   = 5'd12;
  localparam state_e S_RES   = 5'd13;
  localparam state_e S_CLR2  = 5'd14;
  localparam state_e S_DONE  = 5'd15;
  localparam state_e S_ERR   = 5'd16;

  localparam logic [31:0] DMCTRL_ACT    = 32'h0000_0001;
  localparam logic [31:0] DMCTRL_HALT   = 32'h8000_0001;
  localparam logic [31:0] DMCTRL_RESUME = 32'h4000_0001;
  localparam logic [31:0] SBCS_CFG      = 32'h0005_8000;
  localparam logic [31:0] SBCS_OFF      = 32'h0005_0000;
  localparam logic [31:0] CMD_WR_DPC    = 32'h0023_07B1;

  localparam int SBBUSY_BIT    = 21;
  localparam int SBBUSYERR_BIT = 22;
  localparam int SBERR_LSB     = 12;
  localparam int SBERR_MSB     = 14;
  localparam int ANYHALTED_BIT = 8;

endpackage

// File: rtl/dmi_sba_preloader_txn.sv
// Single DMI transaction engine: latches one request on i_start, holds it until accepted,
// then waits for the response and reports done/err/rdata in the response cycle.
module dmi_txn
  import dmi_sba_preloader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_start,
  input  logic [6:0]  i_addr,
  input  dmi_op_e     i_op,
  input  logic [31:0] i_data,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic        o_req_valid,
  input  logic        i_req_ready,
  output logic [6:0]  o_req_addr,
  output logic [1:0]  o_req_op,
  output logic [31:0] o_req_data,
  input  logic        i_resp_valid,
  output logic        o_resp_ready,
  input  logic [31:0] i_resp_data,
  input  logic [1:0]  i_resp_resp
);

  logic        r_req, r_wait;
  logic [6:0]  r_addr;
  logic [1:0]  r_op;
  logic [31:0] r_data;

  // Fields are captured once so they stay stable while the DM stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req  <= 1'b0;
      r_wait <= 1'b0;
      r_addr <= '0;
      r_op   <= '0;
      r_data <= '0;
    end else if (i_start && !r_req && !r_wait) begin
      r_req  <= 1'b1;
      r_addr <= i_addr;
      r_op   <= i_op;
      r_data <= i_data;
    end else if (r_req && i_req_ready) begin
      r_req  <= 1'b0;
      r_wait <= 1'b1;
    end else if (r_wait && i_resp_valid) begin
      r_wait <= 1'b0;
    end
  end

  assign o_req_valid  = r_req;
  assign o_req_addr   = r_addr;
  assign o_req_op     = r_op;
  assign o_req_data   = r_data;
  assign o_resp_ready = r_wait;
  assign o_done       = r_wait & i_resp_valid;
  assign o_err        = o_done & (i_resp_resp != 2'd0);
  assign o_rdata      = i_resp_data;

endmodule

// File: rtl/dmi_sba_preloader.sv
// DMI boot preloader: streams sections into SRAM via SBA, loads DPC and resumes the hart.
// Define DMI_SBA_PRELOAD_POLL_EN to poll SBCS after every SBData0 write.
module dmi_sba_preloader
  import dmi_sba_preloader_pkg::*;
#(
  parameter int POLL_MAX = 1024,
  parameter int LEN_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      start_pc_i,
  input  logic             hdr_valid_i,
  output logic             hdr_ready_o,
  input  logic [31:0]      hdr_addr_i,
  input  logic [LEN_W-1:0] hdr_len_i,
  input  logic             hdr_last_i,
  input  logic             wdata_valid_i,
  output logic             wdata_ready_o,
  input  logic [31:0]      wdata_i,
  output logic             dmi_req_valid_o,
  input  logic             dmi_req_ready_i,
  output logic [6:0]       dmi_req_addr_o,
  output logic [1:0]       dmi_req_op_o,
  output logic [31:0]      dmi_req_data_o,
  input  logic             dmi_resp_valid_i,
  output logic             dmi_resp_ready_o,
  input  logic [31:0]      dmi_resp_data_i,
  input  logic [1:0]       dmi_resp_resp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o
);

  localparam int PW = $clog2(POLL_MAX + 1) + 1;

  state_e           r_state;
  logic             r_issued, r_last;
  logic [31:0]      r_pc, r_addr;
  logic [LEN_W-1:0] r_cnt;
  logic [PW-1:0]    r_poll;

  logic        w_start, w_done, w_err, w_sb_fail, w_unused;
  logic [31:0] w_rdata, w_data;
  logic [6:0]  w_addr;
  dmi_op_e     w_op;

  assign hdr_ready_o   = (r_state == S_HDR);
  assign wdata_ready_o = (r_state == S_DATA) && !r_issued;
  assign busy_o        = !(r_state inside {S_IDLE, S_DONE, S_ERR});
  assign done_o        = (r_state == S_DONE);
  assign error_o       = (r_state == S_ERR);
  assign w_unused      = ^w_rdata;

`ifdef DMI_SBA_PRELOAD_POLL_EN
  assign w_sb_fail = |w_rdata[SBERR_MSB:SBERR_LSB];
`else
  assign w_sb_fail = (|w_rdata[SBERR_MSB:SBERR_LSB]) | w_rdata[SBBUSYERR_BIT];
`endif

  // One request per DMI state; r_issued marks it in flight until the response returns.
  always_comb begin
    w_start = 1'b0;
    w_addr  = DMI_DMCONTROL;
    w_op    = DMI_WRITE;
    w_data  = '0;
    case (r_state)
      S_ACT:   begin w_start = !r_issued; w_data = DMCTRL_ACT; end
      S_SBCFG: begin w_start = !r_issued; w_addr = DMI_SBCS; w_data = SBCS_CFG; end
      S_ADDR:  begin w_start = !r_issued; w_addr = DMI_SBADDR0; w_data = r_addr; end
      S_DATA:  begin w_start = wdata_valid_i && wdata_ready_o; w_addr = DMI_SBDATA0; w_data = wdata_i; end
      S_POLL:  begin w_start = !r_issued; w_addr = DMI_SBCS; w_op = DMI_READ; end
      S_SBOFF: begin w_start = !r_issued; w_addr = DMI_SBCS; w_data = SBCS_OFF; end
      S_PC:    begin w_start = !r_issued; w_addr = DMI_DATA0; w_data = r_pc; end
      S_HALT:  begin w_start = !r_issued; w_data = DMCTRL_HALT; end
      S_WHALT: begin w_start = !r_issued; w_addr = DMI_DMSTATUS; w_op = DMI_READ; end
      S_CLR:   begin w_start = !r_issued; w_data = DMCTRL_ACT; end
      S_CMD:   begin w_start = !r_issued; w_addr = DMI_COMMAND; w_data = CMD_WR_DPC; end
      S_RES:   begin w_start = !r_issued; w_data = DMCTRL_RESUME; end
      S_CLR2:  begin w_start = !r_issued; w_data = DMCTRL_ACT; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_issued <= 1'b0;
      r_last   <= 1'b0;
      r_pc     <= '0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_poll   <= '0;
    end else begin
      if (w_start) r_issued <= 1'b1;
      if (w_done)  r_issued <= 1'b0;
      if (w_err) begin
        r_state <= S_ERR;
      end else begin
        case (r_state)
          S_IDLE: if (start_i) begin r_pc <= start_pc_i; r_state <= S_ACT; end
          S_ACT:   if (w_done) r_state <= S_SBCFG;
          S_SBCFG: if (w_done) r_state <= S_HDR;
          S_HDR: if (hdr_valid_i) begin
            r_addr <= hdr_addr_i;
            r_cnt  <= hdr_len_i;
            r_last <= hdr_last_i;
            if (hdr_len_i != '0) r_state <= S_ADDR;
            else if (hdr_last_i) r_state <= S_SBOFF;
          end
          S_ADDR: if (w_done) begin r_poll <= '0; r_state <= S_POLL; end
          S_DATA: if (w_done) begin
            r_cnt <= r_cnt - 1'b1;
`ifdef DMI_SBA_PRELOAD_POLL_EN
            r_poll  <= '0;
            r_state <= S_POLL;
`else
            if (r_cnt == LEN_W'(1)) begin r_poll <= '0; r_state <= S_POLL; end
`endif
          end
          // A busy read past the budget aborts; read POLL_MAX+1 is the last one.
          S_POLL: if (w_done) begin
            if (w_sb_fail) r_state <= S_ERR;
            else if (w_rdata[SBBUSY_BIT]) begin
              if (r_poll >= PW'(POLL_MAX)) r_state <= S_ERR;
              else r_poll <= r_poll + 1'b1;
            end
            else if (r_cnt != '0) r_state <= S_DATA;
            else if (r_last) r_state <= S_SBOFF;
            else r_state <= S_HDR;
          end
          S_SBOFF: if (w_done) r_state <= S_PC;
          S_PC:    if (w_done) r_state <= S_HALT;
          S_HALT:  if (w_done) begin r_poll <= '0; r_state <= S_WHALT; end
          S_WHALT: if (w_done) begin
            if (w_rdata[ANYHALTED_BIT]) r_state <= S_CLR;
            else if (r_poll >= PW'(POLL_MAX)) r_state <= S_ERR;
            else r_poll <= r_poll + 1'b1;
          end
          S_CLR:   if (w_done) r_state <= S_CMD;
          S_CMD:   if (w_done) r_state <= S_RES;
          S_RES:   if (w_done) r_state <= S_CLR2;
          S_CLR2:  if (w_done) r_state <= S_DONE;
          default: ;
        endcase
      end
    end
  end

  dmi_txn u_txn (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_start      (w_start),
    .i_addr       (w_addr),
    .i_op         (w_op),
    .i_data       (w_data),
    .o_done       (w_done),
    .o_err        (w_err),
    .o_rdata      (w_rdata),
    .o_req_valid  (dmi_req_valid_o),
    .i_req_ready  (dmi_req_ready_i),
    .o_req_addr   (dmi_req_addr_o),
    .o_req_op     (dmi_req_op_o),
    .o_req_data   (dmi_req_data_o),
    .i_resp_valid (dmi_resp_valid_i),
    .o_resp_ready (dmi_resp_ready_o),
    .i_resp_data  (dmi_resp_data_i),
    .i_resp_resp  (dmi_resp_resp_i)
  );

endmodule

// File: tb/tb_dmi_sba_preloader.sv
// Bench for dmi_sba_preloader: DM model + scoreboard of expected DMI requests, directed sections.
`timescale 1ns/1ps
module tb_dmi_sba_preloader;
  localparam int PM = 16;

  logic        clk = 1'b0;
  logic        rst, start_i, hdr_valid_i, hdr_last_i, wdata_valid_i;
  logic [31:0] start_pc_i, hdr_addr_i, wdata_i;
  logic [15:0] hdr_len_i;
  logic        hdr_ready_o, wdata_ready_o, dmi_req_valid_o, dmi_req_ready_i;
  logic [6:0]  dmi_req_addr_o;
  logic [1:0]  dmi_req_op_o, dmi_resp_resp_i;
  logic [31:0] dmi_req_data_o, dmi_resp_data_i;
  logic        dmi_resp_valid_i, dmi_resp_ready_o, busy_o, done_o, error_o;

  dmi_sba_preloader #(.POLL_MAX(PM), .LEN_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .start_pc_i(start_pc_i),
    .hdr_valid_i(hdr_valid_i), .hdr_ready_o(hdr_ready_o), .hdr_addr_i(hdr_addr_i),
    .hdr_len_i(hdr_len_i), .hdr_last_i(hdr_last_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
    .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_op_o(dmi_req_op_o), .dmi_req_data_o(dmi_req_data_o),
    .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o),
    .dmi_resp_data_i(dmi_resp_data_i), .dmi_resp_resp_i(dmi_resp_resp_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [6:0] addr; logic [1:0] op; logic [31:0] data; } req_t;
  typedef struct packed { logic [31:0] addr; logic [15:0] len; logic last; } hdr_t;
  req_t        exp_q[$];
  hdr_t        hdr_q[$];
  logic [31:0] dat_q[$];
  int checks = 0, errors = 0;

  int         busy_reads = 0, stall_cycles = 0;
  bit         never_halt = 0, err_en = 0, hold_data = 0;
  logic [6:0] err_addr = 7'h0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // DM model and scoreboard monitor: each accepted request is popped against exp_q.
  initial begin
    req_t got, e, snap;
    bit pend, err_next;
    logic [31:0] rd;
    logic [1:0]  rr;
    pend = 0; err_next = 0; rd = '0; rr = '0; snap = '0;
    dmi_req_ready_i = 0; dmi_resp_valid_i = 0; dmi_resp_data_i = '0; dmi_resp_resp_i = '0;
    forever begin
      @(negedge clk);
      dmi_resp_valid_i = 0; dmi_resp_resp_i = '0; dmi_req_ready_i = 0;
      if (err_next) begin chk("error_next_cycle", 64'(error_o), 64'd1); err_next = 0; end
      if (rst) begin pend = 0; continue; end
      if (pend) begin
        chk("resp_ready", 64'(dmi_resp_ready_o), 64'd1);
        dmi_resp_valid_i = 1; dmi_resp_data_i = rd; dmi_resp_resp_i = rr; pend = 0;
        if (rr != 2'd0) err_next = 1;
      end else if (dmi_req_valid_o) begin
        got = '{dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o};
        if (hold_data && got.addr == 7'h3C) begin
          if (stall_cycles == 0) snap = got;
          else chk("stall_stable", 64'(got), 64'(snap));
          stall_cycles++;
        end else begin
          dmi_req_ready_i = 1;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req addr=%0h op=%0d data=%0h", got.addr, got.op, got.data);
          end else begin
            e = exp_q.pop_front();
            chk("req_addr", 64'(got.addr), 64'(e.addr));
            chk("req_op", 64'(got.op), 64'(e.op));
            if (e.op == 2'd2) chk("req_data", 64'(got.data), 64'(e.data));
          end
          rd = '0; rr = '0;
          if (err_en && got.addr == err_addr) rr = 2'd2;
          if (got.op == 2'd1 && got.addr == 7'h38 && busy_reads > 0) begin rd[21] = 1; busy_reads--; end
          if (got.op == 2'd1 && got.addr == 7'h11) rd[8] = !never_halt;
          pend = 1;
        end
      end
    end
  end

  // Header / data source fed from hdr_q and dat_q.
  initial begin
    hdr_valid_i = 0; hdr_addr_i = '0; hdr_len_i = '0; hdr_last_i = 0; wdata_valid_i = 0; wdata_i = '0;
    forever begin
      @(negedge clk);
      hdr_valid_i = hdr_q.size() > 0;
      if (hdr_valid_i) begin hdr_addr_i = hdr_q[0].addr; hdr_len_i = hdr_q[0].len; hdr_last_i = hdr_q[0].last; end
      wdata_valid_i = dat_q.size() > 0;
      if (wdata_valid_i) wdata_i = dat_q[0];
      if (!rst && hdr_valid_i && hdr_ready_o) void'(hdr_q.pop_front());
      if (!rst && wdata_valid_i && wdata_ready_o) void'(dat_q.pop_front());
    end
  end

  task automatic tick(int n); repeat (n) @(posedge clk); #1; endtask
  task automatic ew(logic [6:0] a, logic [31:0] d); exp_q.push_back('{a, 2'd2, d}); endtask
  task automatic er(logic [6:0] a); exp_q.push_back('{a, 2'd1, 32'h0}); endtask

  task automatic do_reset();
    rst = 1; start_i = 0; start_pc_i = '0;
    tick(2);
    hdr_q.delete(); dat_q.delete(); exp_q.delete();
    busy_reads = 0; never_halt = 0; err_en = 0; hold_data = 0; stall_cycles = 0;
    rst = 0;
  endtask

  task automatic kick(logic [31:0] pc);
    start_pc_i = pc; start_i = 1; tick(1); start_i = 0;
  endtask

  task automatic prologue(); ew(7'h10, 32'h1); ew(7'h38, 32'h0005_8000); endtask

  task automatic epilogue(logic [31:0] pc);
    ew(7'h38, 32'h0005_0000); ew(7'h04, pc); ew(7'h10, 32'h8000_0001); er(7'h11);
    ew(7'h10, 32'h1); ew(7'h17, 32'h0023_07B1); ew(7'h10, 32'h4000_0001); ew(7'h10, 32'h1);
  endtask

  task automatic section(logic [31:0] addr, int n, logic [31:0] base, bit last, int busy);
    hdr_q.push_back('{addr, 16'(n), last});
    if (n == 0) return;
    ew(7'h39, addr);
    repeat (busy + 1) er(7'h38);
    for (int i = 0; i < n; i++) begin
      dat_q.push_back(base + 32'(i));
      ew(7'h3C, base + 32'(i));
`ifdef DMI_SBA_PRELOAD_POLL_EN
      er(7'h38);
`endif
    end
`ifndef DMI_SBA_PRELOAD_POLL_EN
    er(7'h38);
`endif
  endtask

  task automatic wait_end(string name);
    int n = 0;
    while (!(done_o || error_o) && n < 5000) begin tick(1); n++; end
    if (n >= 5000) begin checks++; errors++; $display("FAIL %s timeout waiting for done/error", name); end
  endtask

  task automatic finish_ok(string name);
    wait_end(name);
    tick(10);
    chk({name, "_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_done"}, 64'(done_o), 64'd1);
    chk({name, "_error"}, 64'(error_o), 64'd0);
    chk({name, "_busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rdy_seen;
    int n;
    rst = 1; start_i = 0; start_pc_i = '0;
    tick(1);
    do_reset();
    chk("rst_hdr_ready", 64'(hdr_ready_o), 64'd0);
    chk("rst_wdata_ready", 64'(wdata_ready_o), 64'd0);
    chk("rst_req_valid", 64'(dmi_req_valid_o), 64'd0);
    chk("rst_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_error", 64'(error_o), 64'd0);

    // Single section of three words, then wakeup; a second start in DONE is ignored.
    prologue();
    section(32'h1000_0000, 3, 32'hA, 1, 0);
    epilogue(32'h1000_0080);
    kick(32'h1000_0080);
    tick(3);
    chk("t1_busy_running", 64'(busy_o), 64'd1);
    finish_ok("t1");
    kick(32'h1234_5678);
    tick(20);
    chk("t1_done_hold", 64'(done_o), 64'd1);

    // Empty section followed by a two-word last section.
    do_reset();
    prologue();
    section(32'h3000_0000, 0, 32'h0, 0, 0);
    section(32'h2000_0000, 2, 32'h55, 1, 0);
    epilogue(32'h2000_0000);
    kick(32'h2000_0000);
    finish_ok("t2");

    // SBCS reports busy for five reads after SBAddress0.
    do_reset();
    busy_reads = 5;
    prologue();
    section(32'h1000_0100, 1, 32'h77, 1, 5);
    epilogue(32'h1000_0100);
    kick(32'h1000_0100);
    finish_ok("t3");
    chk("t3_busy_used", 64'(busy_reads), 64'd0);

    // Hart never halts: POLL_MAX+1 DMStatus reads, then error, no Command write.
    do_reset();
    never_halt = 1;
    prologue();
    section(32'h0, 0, 32'h0, 1, 0);
    ew(7'h38, 32'h0005_0000); ew(7'h04, 32'h4000_0000); ew(7'h10, 32'h8000_0001);
    repeat (PM + 1) er(7'h11);
    kick(32'h4000_0000);
    wait_end("t4");
    tick(20);
    chk("t4_left", 64'(exp_q.size()), 64'd0);
    chk("t4_error", 64'(error_o), 64'd1);
    chk("t4_busy", 64'(busy_o), 64'd0);
    chk("t4_done", 64'(done_o), 64'd0);
    kick(32'h0);
    tick(10);
    chk("t4_error_hold", 64'(error_o), 64'd1);

    // Error response on the SBAddress0 write.
    do_reset();
    err_en = 1; err_addr = 7'h39;
    prologue();
    hdr_q.push_back('{32'h1000_0000, 16'd2, 1'b0});
    hdr_q.push_back('{32'h1000_2000, 16'd1, 1'b1});
    dat_q.push_back(32'h1); dat_q.push_back(32'h2);
    ew(7'h39, 32'h1000_0000);
    kick(32'h0);
    wait_end("t5");
    rdy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      rdy_seen |= hdr_ready_o | wdata_ready_o;
      tick(1);
    end
    chk("t5_no_ready", 64'(rdy_seen), 64'd0);
    chk("t5_error", 64'(error_o), 64'd1);
    chk("t5_left", 64'(exp_q.size()), 64'd0);

    // DM stalls the first SBData0 write; reset lands mid-DATA.
    do_reset();
    hold_data = 1;
    prologue();
    hdr_q.push_back('{32'h1000_0000, 16'd2, 1'b1});
    dat_q.push_back(32'h11); dat_q.push_back(32'h22);
    ew(7'h39, 32'h1000_0000); er(7'h38);
    kick(32'h0);
    n = 0;
    while (stall_cycles < 11 && n < 2000) begin tick(1); n++; end
    if (n >= 2000) begin checks++; errors++; $display("FAIL t6 timeout waiting for stalled SBData0"); end
    chk("t6_busy_stalled", 64'(busy_o), 64'd1);
    chk("t6_one_word_taken", 64'(dat_q.size()), 64'd1);
    rst = 1;
    tick(1);
    chk("t6_rst_req_valid", 64'(dmi_req_valid_o), 64'd0);
    chk("t6_rst_req_fields", 64'({dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o}), 64'd0);
    chk("t6_rst_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
    chk("t6_rst_hdr_ready", 64'(hdr_ready_o), 64'd0);
    chk("t6_rst_wdata_ready", 64'(wdata_ready_o), 64'd0);
    chk("t6_rst_busy", 64'(busy_o), 64'd0);
    chk("t6_rst_done", 64'(done_o), 64'd0);
    chk("t6_rst_error", 64'(error_o), 64'd0);
    chk("t6_left", 64'(exp_q.size()), 64'd0);
    hold_data = 0;
    rst = 0;
    tick(5);
    chk("t6_idle_after", 64'(busy_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmi_sba_preloader.md
Name: dmi_sba_preloader

Overview:
- Hardware boot preloader placed directly upstream of the debug module's DMI port. It replaces the JTAG-driven preload flow.
- Consumes a stream of memory sections: a header carrying address and length, followed by data words. Each section is written into SRAM through System Bus Access.
- After the last section, it wakes Ibex: writes the start PC into DPC via an abstract command, then issues resume.
- Reports busy, done and error to the surrounding boot logic.

Parameters:
- POLL_MAX, 1024, maximum SBCS/DMStatus poll reads before timeout error.
- LEN_W, 16, width of the section word count.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  pulse; starts a preload when in IDLE, ignored otherwise
- start_pc_i  in  32  Ibex start address, sampled on start_i
- hdr_valid_i  in  1  section header valid
- hdr_ready_o  out  1  header accepted
- hdr_addr_i  in  32  section byte address, word aligned
- hdr_len_i  in  LEN_W  number of 32-bit words in the section
- hdr_last_i  in  1  marks the final section
- wdata_valid_i  in  1  data word valid
- wdata_ready_o  out  1  data word accepted
- wdata_i  in  32  data word
- dmi_req_valid_o  out  1  DMI request valid
- dmi_req_ready_i  in  1  DM accepts the request
- dmi_req_addr_o  out  7  DMI register address
- dmi_req_op_o  out  2  1 = read, 2 = write
- dmi_req_data_o  out  32  write data
- dmi_resp_valid_i  in  1  DMI response valid
- dmi_resp_ready_o  out  1  always 1 while waiting for a response
- dmi_resp_data_i  in  32  read data
- dmi_resp_resp_i  in  2  0 = OK
- busy_o  out  1  sequence in progress
- done_o  out  1  level; wakeup complete
- error_o  out  1  level; sequence aborted

Behaviour:
- Clock is clk_i; reset is synchronous, active-high (rst_i).
- Reset values: all valid/ready outputs 0; busy_o, done_o, error_o 0; state IDLE.
- DMI handshake:
  - Requests complete on dmi_req_valid_o & dmi_req_ready_i.
  - Request fields stay stable while valid and not ready.
  - Exactly one request is outstanding; the next request is issued no earlier than the cycle after the response.
  - A response with dmi_resp_resp_i != 0 goes to ERR.
- FSM, one DMI transaction per state:
  - IDLE
  - ACT: write DMControl (0x10) = 0x0000_0001
  - SBCFG: write SBCS (0x38) = 0x0005_8000 (sbaccess=2, sbautoincrement, sbreadondata)
  - HDR: hdr_ready_o=1 for one cycle on accept
  - ADDR: write SBAddress0 (0x39) = hdr_addr_i
  - DATA: wdata_ready_o=1 for one cycle on accept, then write SBData0 (0x3C)
  - POLL: read SBCS until bit21 (sbbusy) = 0. If bits14:12 (sberror) != 0, go to ERR.
  - SBOFF: write SBCS = 0x0005_0000
  - PC: write Data0 (0x04) = start_pc
  - HALT: write DMControl = 0x8000_0001
  - WHALT: read DMStatus (0x11) until bit8 (anyhalted)
  - CLR: write DMControl = 0x0000_0001
  - CMD: write Command (0x17) = 0x0023_07B1 (transfer, write, aarsize=2, regno DPC)
  - RES: write DMControl = 0x4000_0001
  - CLR2: write DMControl = 0x0000_0001
  - DONE
- Transitions:
  - ACT → SBCFG → HDR.
  - HDR with hdr_len_i = 0 → SBOFF if last, else HDR; no ADDR write is issued.
  - ADDR → POLL. Remaining word count is loaded from hdr_len_i.
  - DATA → POLL. The count decrements on the SBData0 write response.
  - POLL (not busy) → DATA while count > 0; otherwise SBOFF if last, else HDR.
  - SBOFF → PC → HALT → WHALT → CLR → CMD → RES → CLR2 → DONE.
- Poll limits: the poll counter resets on entry to POLL and WHALT. Exceeding POLL_MAX reads → ERR.
- DONE and ERR:
  - Both hold until rst_i.
  - start_i is ignored in DONE and ERR.
  - busy_o = state ∉ {IDLE, DONE, ERR}.
- rst_i mid-operation: immediate return to IDLE. Any outstanding DMI request is dropped; the DM must be reset alongside.

Optional Feature:
- Macro: DMI_SBA_PRELOAD_POLL_EN.
- Defined: a POLL (SBCS read until not busy) follows every SBData0 write.
- Undefined: DATA writes are issued back-to-back. POLL runs only after ADDR and once after the last word of each section, where sberror and sbbusyerror (bit22) are checked and either one → ERR.

Decomposition:
- Package dmi_sba_preloader_pkg:
  - DMI address localparams
  - dmi_op_e
  - state_e
  - SBCS/DMControl/Command constant words
  - bit index constants for sbbusy, sberror, anyhalted
- Sub-module dmi_txn: single-transaction req/resp engine. Inputs are a start pulse plus addr/op/data; outputs are done, rdata and err. The main FSM sequences over it.

Test Plan:
- Single section, addr 0x1000_0000, 3 words (0xA, 0xB, 0xC), last, start_pc 0x1000_0080.
  - DMI write order: 0x10←1, 0x38←0x58000, 0x39←0x1000_0000, three 0x3C writes, 0x38←0x50000, 0x04←0x1000_0080, 0x10←0x8000_0001, …, 0x17←0x0023_07B1, 0x10←0x4000_0001, 0x10←1.
  - done_o=1.
- Two sections, lengths 0 then 2 (last): no SBAddress0 write for the first section; two SBData0 writes; done_o=1.
- SBCS read returns sbbusy=1 for 5 reads, then 0: exactly 6 SBCS reads follow that write; the sequence continues.
- DMStatus bit8 never set: exactly POLL_MAX+1 reads, then error_o=1, busy_o=0, no Command write.
- dmi_resp_resp_i=2 on the SBAddress0 write: error_o=1 next cycle; hdr_ready_o and wdata_ready_o stay 0 afterwards.
- dmi_req_ready_i held low 10 cycles; rst_i asserted mid-DATA: all request fields stable while stalled; one cycle after rst_i, state IDLE and all outputs 0.
